// File: rtl/conv_out_seq.sv
// Output sequencer for the convolution pipeline.
// Tracks the output raster position, tags each accepted kernel window with
// start-of-frame / end-of-line / end-of-frame, and presents the tagged beats
// on an AXI-stream master through a 2-entry FIFO that absorbs ready stalls.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no frame in progress on the input side (next beat is sof)
// ACTIVE | at least one beat of the current frame accepted, eof not yet
module conv_out_seq #(
  parameter int DATA_W = 200,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld_i,
  input  logic [DATA_W-1:0] in_dat_i,
  output logic              in_rdy_o,
  input  logic              m_tready_i,
  output logic              m_tvalid_o,
  output logic [DATA_W-1:0] m_tdata_o,
  output logic              m_tuser_o,
  output logic              m_tlast_o,
  output logic              frame_done_o,
  output logic              busy_o,
  output logic              ovf_err_o
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state, state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic [1:0]        count;
  logic              rd_ptr, wr_ptr;
  logic [DATA_W-1:0] fifo_dat [2];
  logic [1:0]        fifo_sof, fifo_eol, fifo_eof;

  logic accept, drop, pop;
  logic tag_sof, tag_eol, tag_eof;
  logic frame_done_q, ovf_q;

  // Space is decoded from the registered count only, so a same-cycle pop
  // never makes room for a push when the buffer is full.
  assign in_rdy_o = (count != 2'd2);
  assign accept   = in_vld_i & in_rdy_o;
  assign drop     = in_vld_i & ~in_rdy_o;
  assign pop      = m_tvalid_o & m_tready_i;

  assign tag_sof = (col == '0) && (row == '0);
  assign tag_eol = (col == COL_MAX);
  assign tag_eof = tag_eol && (row == ROW_MAX);

  assign m_tvalid_o   = (count != 2'd0);
  assign m_tdata_o    = m_tvalid_o ? fifo_dat[rd_ptr] : '0;
  assign m_tuser_o    = m_tvalid_o & fifo_sof[rd_ptr];
  assign m_tlast_o    = m_tvalid_o & fifo_eol[rd_ptr];
  assign frame_done_o = frame_done_q;
  assign ovf_err_o    = ovf_q;
  assign busy_o       = (state == ACTIVE) | m_tvalid_o;

  // Raster position: advances only on accepted beats, wraps at line/frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (tag_eol) begin
        col <= '0;
        row <= tag_eof ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (accept) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the entry is not occupied.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_dat[wr_ptr] <= in_dat_i;
      fifo_sof[wr_ptr] <= tag_sof;
      fifo_eol[wr_ptr] <= tag_eol;
      fifo_eof[wr_ptr] <= tag_eof;
    end
  end

  // Frame-done pulse follows the hand-off of an eof beat; overflow is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      frame_done_q <= pop & fifo_eof[rd_ptr];
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Input-side FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Input-side FSM next-state: a frame opens on any non-eof beat and closes on eof.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !tag_eof) state_nxt = ACTIVE;
      ACTIVE:  if (accept && tag_eof)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_out_seq.sv
// Directed bench for conv_out_seq with a 4x2 raster.
module tb_conv_out_seq;

  localparam int DATA_W = 200;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_vld;
  logic [DATA_W-1:0] in_dat;
  logic              in_rdy;
  logic              m_tready;
  logic              m_tvalid;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tuser;
  logic              m_tlast;
  logic              frame_done;
  logic              busy;
  logic              ovf_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic              sof;
    logic              eol;
    logic              eof;
  } beat_t;

  conv_out_seq #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_vld_i     (in_vld),
    .in_dat_i     (in_dat),
    .in_rdy_o     (in_rdy),
    .m_tready_i   (m_tready),
    .m_tvalid_o   (m_tvalid),
    .m_tdata_o    (m_tdata),
    .m_tuser_o    (m_tuser),
    .m_tlast_o    (m_tlast),
    .frame_done_o (frame_done),
    .busy_o       (busy),
    .ovf_err_o    (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream n beats with data 1..n at full rate with ready held high.
  task automatic stream(input int n);
    m_tready = 1'b1;
    for (int k = 1; k <= n; k++) begin
      in_vld = 1'b1;
      in_dat = DATA_W'(k);
      step();
      check("s_vld",  DATA_W'(m_tvalid), DATA_W'(1));
      check("s_dat",  m_tdata, DATA_W'(k));
      check("s_user", DATA_W'(m_tuser), DATA_W'(((k - 1) % 8) == 0));
      check("s_last", DATA_W'(m_tlast), DATA_W'((k % 4) == 0));
      check("s_fd",   DATA_W'(frame_done), DATA_W'((k > 1) && (((k - 1) % 8) == 0)));
    end
    in_vld = 1'b0;
    step();
    check("s_fd_end",  DATA_W'(frame_done), DATA_W'(1));
    check("s_vld_end", DATA_W'(m_tvalid), DATA_W'(0));
    step();
    check("s_fd_off",  DATA_W'(frame_done), DATA_W'(0));
    check("s_busy",    DATA_W'(busy), DATA_W'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    beat_t q[$];
    int    col, row, sent;
    logic  prev_stall;
    logic [DATA_W-1:0] prev_dat;
    logic  prev_user, prev_last, fd_exp;

    rst = 1'b1; in_vld = 1'b0; in_dat = '0; m_tready = 1'b1;
    step(); step();
    check("rst_vld",  DATA_W'(m_tvalid), DATA_W'(0));
    check("rst_rdy",  DATA_W'(in_rdy), DATA_W'(1));
    check("rst_busy", DATA_W'(busy), DATA_W'(0));
    check("rst_ovf",  DATA_W'(ovf_err), DATA_W'(0));
    check("rst_dat",  m_tdata, DATA_W'(0));
    rst = 1'b0;

    // one frame at full rate
    stream(8);
    check("t1_ovf", DATA_W'(ovf_err), DATA_W'(0));

    // stall with two beats buffered, then a dropped third beat
    m_tready = 1'b0;
    in_vld = 1'b1; in_dat = DATA_W'('hA0);
    step();
    check("t2_vld",  DATA_W'(m_tvalid), DATA_W'(1));
    check("t2_headA", m_tdata, DATA_W'('hA0));
    check("t2_userA", DATA_W'(m_tuser), DATA_W'(1));
    check("t2_rdy1", DATA_W'(in_rdy), DATA_W'(1));
    in_dat = DATA_W'('hB0);
    step();
    check("t2_rdy0", DATA_W'(in_rdy), DATA_W'(0));
    check("t2_holdA", m_tdata, DATA_W'('hA0));
    in_dat = DATA_W'('hC0);
    step();
    check("t3_ovf", DATA_W'(ovf_err), DATA_W'(1));
    check("t3_holdA", m_tdata, DATA_W'('hA0));
    check("t3_userA", DATA_W'(m_tuser), DATA_W'(1));
    in_vld = 1'b0;
    step();
    check("t3_holdA2", m_tdata, DATA_W'('hA0));
    m_tready = 1'b1;
    step();
    check("t2_headB", m_tdata, DATA_W'('hB0));
    check("t2_userB", DATA_W'(m_tuser), DATA_W'(0));
    check("t2_lastB", DATA_W'(m_tlast), DATA_W'(0));
    check("t2_rdyB",  DATA_W'(in_rdy), DATA_W'(1));
    step();
    check("t2_empty", DATA_W'(m_tvalid), DATA_W'(0));
    check("t2_zero",  m_tdata, DATA_W'(0));
    in_vld = 1'b1; in_dat = DATA_W'('hD0);
    step();
    check("t3_datD",  m_tdata, DATA_W'('hD0));
    check("t3_userD", DATA_W'(m_tuser), DATA_W'(0));
    check("t3_lastD", DATA_W'(m_tlast), DATA_W'(0));
    in_dat = DATA_W'('hE0);
    step();
    check("t3_lastE", DATA_W'(m_tlast), DATA_W'(1));
    for (int j = 0; j < 4; j++) begin
      in_dat = DATA_W'(16 + j);
      step();
      check("t3_row1", m_tdata, DATA_W'(16 + j));
      check("t3_last", DATA_W'(m_tlast), DATA_W'(j == 3));
    end
    in_vld = 1'b0;
    step();
    check("t3_fd",   DATA_W'(frame_done), DATA_W'(1));
    check("t3_ovf2", DATA_W'(ovf_err), DATA_W'(1));
    step();

    // two frames back-to-back
    stream(16);

    // reset mid-frame with one entry buffered
    for (int k = 1; k <= 3; k++) begin
      in_vld = 1'b1; in_dat = DATA_W'(k);
      step();
    end
    in_vld = 1'b0; rst = 1'b1;
    step();
    check("t5_vld",  DATA_W'(m_tvalid), DATA_W'(0));
    check("t5_dat",  m_tdata, DATA_W'(0));
    check("t5_user", DATA_W'(m_tuser), DATA_W'(0));
    check("t5_last", DATA_W'(m_tlast), DATA_W'(0));
    check("t5_fd",   DATA_W'(frame_done), DATA_W'(0));
    check("t5_busy", DATA_W'(busy), DATA_W'(0));
    check("t5_ovf",  DATA_W'(ovf_err), DATA_W'(0));
    check("t5_rdy",  DATA_W'(in_rdy), DATA_W'(1));
    rst = 1'b0;
    step();
    check("t5_fd2", DATA_W'(frame_done), DATA_W'(0));
    in_vld = 1'b1; in_dat = DATA_W'('h55);
    step();
    check("t5_sof", DATA_W'(m_tuser), DATA_W'(1));
    in_vld = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;

    // random ready, input every other cycle, four frames
    col = 0; row = 0; sent = 0;
    for (int cyc = 0; cyc < 400 && !(sent == 32 && q.size() == 0); cyc++) begin
      in_vld   = ((cyc % 2) == 0) && (sent < 32);
      in_dat   = DATA_W'(sent + 256);
      m_tready = (q.size() == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      prev_stall = m_tvalid && !m_tready;
      prev_dat   = m_tdata;
      prev_user  = m_tuser;
      prev_last  = m_tlast;
      step();
      fd_exp = 1'b0;
      if (q.size() != 0 && m_tready) begin
        fd_exp = q[0].eof;
        void'(q.pop_front());
      end
      if (in_vld) begin
        q.push_back({in_dat, 1'(col == 0 && row == 0), 1'(col == IMG_W - 1),
                     1'(col == IMG_W - 1 && row == IMG_H - 1)});
        if (col == IMG_W - 1) begin
          col = 0;
          row = (row == IMG_H - 1) ? 0 : row + 1;
        end else begin
          col++;
        end
        sent++;
      end
      check("t6_vld", DATA_W'(m_tvalid), DATA_W'(q.size() != 0));
      check("t6_fd",  DATA_W'(frame_done), DATA_W'(fd_exp));
      check("t6_ovf", DATA_W'(ovf_err), DATA_W'(0));
      if (q.size() != 0) begin
        check("t6_dat",  m_tdata, q[0].dat);
        check("t6_user", DATA_W'(m_tuser), DATA_W'(q[0].sof));
        check("t6_last", DATA_W'(m_tlast), DATA_W'(q[0].eol));
      end
      if (prev_stall) begin
        check("t6_stable_dat",  m_tdata, prev_dat);
        check("t6_stable_user", DATA_W'(m_tuser), DATA_W'(prev_user));
        check("t6_stable_last", DATA_W'(m_tlast), DATA_W'(prev_last));
      end
    end
    check("t6_drain", DATA_W'(q.size() == 0 && sent == 32), DATA_W'(1));
    step();
    check("t6_busy", DATA_W'(busy), DATA_W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
